// File: rtl/pcw_line_fetch.sv
// pcw_line_fetch: per-scanline roller lookup, byte prefetch through a small FIFO,
// and 1 bpp serialisation of the fetched bytes onto the pixel stream.
module pcw_line_fetch #(
  parameter int BYTES_PER_LINE = 90,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_linestart,
  input  logic        i_active,
  input  logic        i_vblank,
  input  logic [8:0]  i_y,
  input  logic [16:0] i_roller_addr,
  input  logic        i_invert,
  output logic        o_mem_rd,
  output logic [16:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_pixel,
  output logic        o_underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BYTES_PER_LINE + 1);
  localparam logic [BW-1:0] LAST = BW'(BYTES_PER_LINE - 1);
  typedef enum logic [2:0] {IDLE, ROLL_LO, ROLL_HI, FETCH, DONE} state_t;
  state_t state, nxt;
  logic [16:0] roll_base, line_addr;
  logic [7:0] entry_lo, sr;
  logic [BW-1:0] byte_cnt;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [2:0] bit_cnt;
  logic gap, ls, ack, push, pop, empty, full, act_stb, at_byte;
  assign ls = i_pix_stb & i_linestart;
  assign ack = i_mem_ack & o_mem_rd;
  assign push = ack & (state == FETCH);
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign act_stb = i_pix_stb & i_active;
  assign at_byte = act_stb & (bit_cnt == 3'd0);
  assign pop = at_byte & ~empty;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ROLL_LO: if (ack) nxt = ROLL_HI;
      ROLL_HI: if (ack) nxt = FETCH;
      FETCH:   if (ack && byte_cnt == LAST) nxt = DONE;
      default: ;
    endcase
    if (ls) nxt = i_vblank ? IDLE : ROLL_LO;
  end
  // gap forces the one idle cycle between an ack and the next request
  always_comb begin
    o_mem_rd = !gap && (state == ROLL_LO || state == ROLL_HI || (state == FETCH && !full));
    o_mem_addr = state == ROLL_LO ? roll_base :
                 state == ROLL_HI ? roll_base + 17'd1 :
                 state == FETCH   ? line_addr + 17'({byte_cnt, 3'b000}) : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      gap <= 1'b0;
      roll_base <= '0;
      line_addr <= '0;
      entry_lo <= '0;
      byte_cnt <= '0;
    end else begin
      gap <= ack & ~ls;
      if (ls && !i_vblank) begin
        roll_base <= i_roller_addr + {7'd0, i_y, 1'b0};
        byte_cnt <= '0;
      end else if (push) byte_cnt <= byte_cnt + BW'(1);
      if (ack && state == ROLL_LO) entry_lo <= i_mem_data;
      if (ack && state == ROLL_HI)
        line_addr <= {i_mem_data[7:5], i_mem_data[4:0], entry_lo[7:4], 2'b00, entry_lo[2:0]};
    end
  always_ff @(posedge i_clk)
    if (push) fifo[wr_ptr] <= i_mem_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (ls) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // an empty FIFO at a byte boundary serialises a blank byte
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bit_cnt <= '0;
      sr <= '0;
      o_pixel <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      if (ls && !i_vblank) bit_cnt <= '0;
      else if (act_stb) bit_cnt <= bit_cnt + 3'd1;
      if (act_stb) sr <= bit_cnt != 3'd0 ? {sr[6:0], 1'b0} : empty ? 8'h00 : {fifo[rd_ptr][6:0], 1'b0};
      if (i_pix_stb) o_pixel <= i_active & ((bit_cnt != 3'd0 ? sr[7] : (!empty & fifo[rd_ptr][7])) ^ i_invert);
      if (at_byte && empty) o_underrun <= 1'b1;
    end
endmodule
